auth_blk: RTL



---
 rtl/segway_pkg.sv | 13 +
 rtl/uart_rx.sv | 131 +++++++++++++
 rtl/auth_blk.sv | 78 +++++++
 3 files changed

// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway command path.
//   auth_state_t : power-authorization FSM states
//   rx_state_t   : UART receiver states
//   CMD_GO/STOP  : BLE command bytes ('g' and 's')
package segway_pkg;

  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
  typedef enum logic {IDLE, RECEIVE} rx_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   RX         : serial input, idles high, asynchronous to clk
//   clr_rdy    : consumer acknowledge; rdy drops the following cycle
//   rx_data    : last good byte
//   rdy        : a good byte is waiting in rx_data
//   frm_err    : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import segway_pkg::*;
#(
  parameter int BAUD_CYCLES = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  // Counter reloads are "cycles minus one" because the sample is taken on the
  // cycle the counter reads zero.
  localparam logic [12:0] HALF_LOAD = 13'(BAUD_CYCLES / 2 - 1);
  localparam logic [12:0] FULL_LOAD = 13'(BAUD_CYCLES - 1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t   state_q, state_d;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frm_err_q, frm_err_d;

  logic        start_edge;
  logic        sample;
  logic [9:0]  shift_in;
  logic        start_bit_unused;

  // Synchronizer presets high so reset never looks like a start edge;
  // rx_prev_q only exists for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Edge (not level) start detection: a held-low line yields one frame only.
  assign start_edge = rx_prev_q & ~rx_sync_q;
  assign sample     = (baud_cnt_q == 13'd0);
  assign shift_in   = {rx_sync_q, shift_q[9:1]};
  // The start bit lands in bit 0 but is judged live at sample time instead.
  assign start_bit_unused = shift_q[0];

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = 1'b0;

    if (clr_rdy) rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = RECEIVE;
          baud_cnt_d = HALF_LOAD;
          bit_cnt_d  = 4'd0;
          rdy_d      = 1'b0;    // an unconsumed byte is dropped
        end
      end
      RECEIVE: begin
        if (sample) begin
          shift_d    = shift_in;
          baud_cnt_d = FULL_LOAD;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0 && rx_sync_q) begin
            state_d = IDLE;     // start bit gone high: glitch
          end else if (bit_cnt_q == 4'd9) begin
            state_d = IDLE;
            if (rx_sync_q) begin
              rx_data_d = shift_in[8:1];
              rdy_d     = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: rtl/auth_blk.sv
// Rider-authorization front end: UART command receiver plus power FSM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   RX         : BLE UART serial input
//   rider_off  : load cells report no rider on the platform
//   pwr_up     : registered; high while balancing/driving is authorized
//   rx_err     : one-cycle pulse per framing error
module auth_blk
  import segway_pkg::*;
#(
  parameter int BAUD_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  input  logic rider_off,
  output logic pwr_up,
  output logic rx_err
);

  logic [7:0]  rx_data;
  logic        rdy;
  logic        clr_rdy;
  logic        frm_err;

  auth_state_t state_q, state_d;
  logic        pwr_up_q, pwr_up_d;
  logic        rx_err_q;

  uart_rx #(.BAUD_CYCLES(BAUD_CYCLES)) u_uart_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always_comb begin
    state_d = state_q;
    // Every byte is acknowledged whether or not it matches a command.
    clr_rdy = rdy;

    case (state_q)
      OFF: begin
        if (rdy && rx_data == CMD_GO) state_d = PWR1;
      end
      PWR1: begin
        if (rdy && rx_data == CMD_STOP) state_d = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        // Dismount wins over a simultaneous 'g'; that byte is still consumed.
        if (rider_off)                     state_d = OFF;
        else if (rdy && rx_data == CMD_GO) state_d = PWR1;
      end
      default: state_d = OFF;
    endcase

    pwr_up_d = (state_d != OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      pwr_up_q <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwr_up_q <= pwr_up_d;
      rx_err_q <= frm_err;
    end
  end

  assign pwr_up = pwr_up_q;
  assign rx_err = rx_err_q;

endmodule
